// File: rtl/bridge_pkg.sv
// Shared AHB/APB bridge encodings and error-responder state type.
// Pure definitions: no latency and no backpressure of its own.
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_S0   = 3'b001;
    localparam logic [2:0] SEL_S1   = 3'b010;
    localparam logic [2:0] SEL_S2   = 3'b100;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } err_state_e;

    // Only byte/half/word are accepted, each naturally aligned.
    function automatic logic size_aligned(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic ok;
        case (hsize)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~addr_lo[0];
            3'b010:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational APB slave decode plus size/alignment legality of the current address phase.
// Zero latency; no backpressure.
module ahb_addr_decode
    import bridge_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = 32'h8000_0000,
    parameter logic [31:0] S1_BASE     = 32'h8400_0000,
    parameter logic [31:0] S2_BASE     = 32'h8800_0000,
    parameter int          REGION_BITS = 26
) (
    input  logic [31-REGION_BITS:0] i_addr_tag,
    input  logic [1:0]              i_addr_lo,
    input  logic [2:0]              i_hsize,
    output logic [2:0]              o_temp_selx,
    output logic                    o_mapped,
    output logic                    o_legal
);

    logic [31-REGION_BITS:0] w_s0_tag;
    logic [31-REGION_BITS:0] w_s1_tag;
    logic [31-REGION_BITS:0] w_s2_tag;

    assign w_s0_tag = S0_BASE[31:REGION_BITS];
    assign w_s1_tag = S1_BASE[31:REGION_BITS];
    assign w_s2_tag = S2_BASE[31:REGION_BITS];

    always_comb begin
        o_temp_selx = SEL_NONE;
        if (i_addr_tag == w_s0_tag) begin
            o_temp_selx = SEL_S0;
        end else if (i_addr_tag == w_s1_tag) begin
            o_temp_selx = SEL_S1;
        end else if (i_addr_tag == w_s2_tag) begin
            o_temp_selx = SEL_S2;
        end
    end

    assign o_mapped = (o_temp_selx != SEL_NONE);
    assign o_legal  = size_aligned(i_hsize, i_addr_lo);

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: qualifies beats, decodes the slave, pipelines addr/data 1-2 beats, raises 2-cycle ERROR.
// valid/temp_selx are 0-latency; pipeline advances only on hreadyin; err_hready stalls the master for the first ERROR cycle.
module ahb_slave_if
    import bridge_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = 32'h8000_0000,
    parameter logic [31:0] S1_BASE     = 32'h8400_0000,
    parameter logic [31:0] S2_BASE     = 32'h8800_0000,
    parameter int          REGION_BITS = 26
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic        valid,
    output logic [2:0]  temp_selx,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwritereg,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp,
    output logic        err_hready
);

    logic [31:0] r_haddr1;
    logic [31:0] r_haddr2;
    logic [31:0] r_hwdata1;
    logic [31:0] r_hwdata2;
    logic        r_hwritereg;
    err_state_e  r_err_state;
    err_state_e  w_err_next;
    logic        w_mapped;
    logic        w_legal;
    logic        w_active;
    logic        w_bad_beat;

    ahb_addr_decode #(
        .S0_BASE     (S0_BASE),
        .S1_BASE     (S1_BASE),
        .S2_BASE     (S2_BASE),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .i_addr_tag  (haddr[31:REGION_BITS]),
        .i_addr_lo   (haddr[1:0]),
        .i_hsize     (hsize),
        .o_temp_selx (temp_selx),
        .o_mapped    (w_mapped),
        .o_legal     (w_legal)
    );

    // NONSEQ/SEQ only; IDLE and BUSY never qualify and never error.
    assign w_active   = hreadyin & htrans[1];
    assign w_bad_beat = w_active & ~(w_mapped & w_legal);
    assign valid      = w_active & w_mapped & w_legal & (r_err_state == E_IDLE);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_haddr1    <= '0;
            r_haddr2    <= '0;
            r_hwdata1   <= '0;
            r_hwdata2   <= '0;
            r_hwritereg <= 1'b0;
        end else if (hreadyin) begin
            r_haddr1    <= haddr;
            r_haddr2    <= r_haddr1;
            r_hwdata1   <= hwdata;
            r_hwdata2   <= r_hwdata1;
            r_hwritereg <= hwrite;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_err_state <= E_IDLE;
        end else begin
            r_err_state <= w_err_next;
        end
    end

    // Bad beats arriving in E_ERR1/E_ERR2 are dropped; the master re-presents them.
    always_comb begin
        w_err_next = r_err_state;
        hresp      = HRESP_OKAY;
        err_hready = 1'b1;
        case (r_err_state)
            E_IDLE: begin
                if (w_bad_beat) begin
                    w_err_next = E_ERR1;
                end
            end
            E_ERR1: begin
                hresp      = HRESP_ERROR;
                err_hready = 1'b0;
                w_err_next = E_ERR2;
            end
            E_ERR2: begin
                hresp      = HRESP_ERROR;
                w_err_next = E_IDLE;
            end
            default: begin
                w_err_next = E_IDLE;
            end
        endcase
    end

    assign haddr1    = r_haddr1;
    assign haddr2    = r_haddr2;
    assign hwdata1   = r_hwdata1;
    assign hwdata2   = r_hwdata2;
    assign hwritereg = r_hwritereg;
    assign hrdata    = prdata;

endmodule
